// File: rtl/nco_wave_gen.sv
// NCO core: 5-bit phase accumulator driving an eight-shape waveform table,
// with a minimum hold window between waveform select changes.
module nco_wave_gen #(
    parameter int SELECT_WIDTH = 3,
    parameter int WAVE_WIDTH   = 8,
    parameter int HOLD_CYCLES  = 32
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    enable,
    input  logic [SELECT_WIDTH-1:0] signal_in,
    input  logic [4:0]              phase_inc,
    output logic [SELECT_WIDTH-1:0] signal_out,
    output logic [WAVE_WIDTH-1:0]   wave_out,
    output logic                    busy
);

    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] HOLD_MAX = CW'(HOLD_CYCLES - 1);
    localparam int SHIFT = WAVE_WIDTH - 5;
    localparam logic [WAVE_WIDTH-1:0] HALF = WAVE_WIDTH'(1) << (WAVE_WIDTH - 1);

    // Quarter-wave sine in Q16, mirrored/negated to cover all 32 phases,
    // so the table is built with integer arithmetic at elaboration.
    function automatic logic [WAVE_WIDTH-1:0] sine_at(input int p);
        int     k;
        longint q;
        longint h;
        longint mag;
        k = p % 16;
        if (k > 8) k = 16 - k;
        case (k)
            1:       q = 12785;
            2:       q = 25080;
            3:       q = 36410;
            4:       q = 46341;
            5:       q = 54491;
            6:       q = 60547;
            7:       q = 64277;
            8:       q = 65536;
            default: q = 0;
        endcase
        h   = longint'(1) << (WAVE_WIDTH - 1);
        mag = ((h - 1) * q + 32768) >>> 16;
        if (p < 16) return WAVE_WIDTH'(h + mag);
        else        return WAVE_WIDTH'(h - mag);
    endfunction

    logic [WAVE_WIDTH-1:0] sine_lut [32];

    for (genvar i = 0; i < 32; i++) begin : g_sine
        assign sine_lut[i] = sine_at(i);
    end

    logic [4:0]            phase;
    logic [CW-1:0]         hold_cnt;
    logic                  do_switch;
    logic [WAVE_WIDTH-1:0] wave_next;
    logic [WAVE_WIDTH-1:0] ph_up;
    logic [WAVE_WIDTH-1:0] ph_down;

    assign busy      = (hold_cnt != HOLD_MAX);
    assign do_switch = (signal_in != signal_out) && (hold_cnt == HOLD_MAX);

    always_comb begin
        wave_next = '0;
        ph_up     = WAVE_WIDTH'(phase);
        ph_down   = WAVE_WIDTH'(5'd31 - phase);
        case (int'(signal_out))
            1:       wave_next = sine_lut[phase];
            2:       wave_next = sine_lut[5'(phase + 5'd8)];
            3:       wave_next = phase[4] ? '0 : '1;
            4:       wave_next = ph_up << SHIFT;
            5:       wave_next = ph_down << SHIFT;
            6:       wave_next = phase[4] ? (ph_down << (SHIFT + 1)) : (ph_up << (SHIFT + 1));
            7:       wave_next = HALF;
            default: wave_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            signal_out <= '0;
            wave_out   <= '0;
            phase      <= '0;
            hold_cnt   <= HOLD_MAX;
        end else begin
            wave_out <= wave_next;
            if (do_switch) begin
                signal_out <= signal_in;
                phase      <= '0;
                hold_cnt   <= '0;
            end else begin
                if (enable) phase <= phase + phase_inc;
                if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_nco_wave_gen.sv
// Self-checking bench for nco_wave_gen: time-based behavioural model plus
// directed literal checks from the test plan, then randomized traffic.
module tb_nco_wave_gen;

    localparam int SW   = 3;
    localparam int WW   = 8;
    localparam int HOLD = 32;
    localparam int M    = (1 << WW) - 1;
    localparam int H    = 1 << (WW - 1);
    localparam int S    = WW - 5;
    localparam real PI  = 3.14159265358979323846;

    logic          clk;
    logic          resetn;
    logic          enable;
    logic [SW-1:0] signal_in;
    logic [4:0]    phase_inc;
    logic [SW-1:0] signal_out;
    logic [WW-1:0] wave_out;
    logic          busy;

    nco_wave_gen #(
        .SELECT_WIDTH(SW),
        .WAVE_WIDTH  (WW),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .enable    (enable),
        .signal_in (signal_in),
        .phase_inc (phase_inc),
        .signal_out(signal_out),
        .wave_out  (wave_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Sample value straight from the waveform definitions.
    function automatic int ref_wave(input int sel, input int ph);
        real s;
        int  p;
        int  r;
        case (sel)
            1, 2: begin
                p = (sel == 2) ? (ph + 8) % 32 : ph;
                s = (H - 1) * $sin(2.0 * PI * p / 32.0);
                r = (s >= 0.0) ? $rtoi(s + 0.5) : -$rtoi(0.5 - s);
                return H + r;
            end
            3:       return (ph < 16) ? M : 0;
            4:       return (ph << S) & M;
            5:       return ((31 - ph) << S) & M;
            6:       return (ph < 16) ? ((ph << (S + 1)) & M) : (((31 - ph) << (S + 1)) & M);
            7:       return H;
            default: return 0;
        endcase
    endfunction

    // Model: switch permission is measured as edges elapsed since the last switch.
    int edge_n  = 0;
    int m_last  = 0;
    int m_sel   = 0;
    int m_phase = 0;
    int m_wave  = 0;
    bit m_busy  = 1'b0;

    always @(posedge clk) begin
        edge_n++;
        if (resetn) begin
            m_sel   = 0;
            m_phase = 0;
            m_wave  = 0;
            m_last  = edge_n - (HOLD - 1);
        end else begin
            m_wave = ref_wave(m_sel, m_phase);
            if ((edge_n - m_last) >= HOLD && int'(signal_in) != m_sel) begin
                m_sel   = int'(signal_in);
                m_phase = 0;
                m_last  = edge_n;
            end else if (enable) begin
                m_phase = (m_phase + int'(phase_inc)) % 32;
            end
        end
        m_busy = (edge_n - m_last) < (HOLD - 1);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_signal_out", 32'(signal_out), 32'(m_sel));
            chk("model_wave_out", 32'(wave_out), 32'(m_wave));
            chk("model_busy", 32'(busy), 32'(m_busy));
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        int sine_exp [5] = '{128, 255, 128, 1, 128};

        resetn    = 1'b1;
        enable    = 1'b0;
        signal_in = 3'd3;
        phase_inc = 5'd0;

        // Reset held for three edges with a pending request.
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("reset_signal_out", 32'(signal_out), 32'd0);
        chk("reset_wave_out", 32'(wave_out), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        resetn = 1'b0;
        @(negedge clk);
        chk("post_reset_signal_out", 32'(signal_out), 32'd3);
        chk("post_reset_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("post_reset_square", 32'(wave_out), 32'd255);

        // Hold window with a sine sweep running underneath.
        wait_idle();
        signal_in = 3'd1;
        enable    = 1'b1;
        phase_inc = 5'd8;
        for (int k = 0; k <= 33; k++) begin
            @(negedge clk);
            if (k >= 1 && k <= 5) chk("sine_sweep", 32'(wave_out), 32'(sine_exp[k - 1]));
            if (k == 4) signal_in = 3'd4;
            if (k >= 5 && k <= 30) begin
                chk("hold_signal_out", 32'(signal_out), 32'd1);
                chk("hold_busy", 32'(busy), 32'd1);
            end
            if (k == 31) begin
                chk("hold_end_signal_out", 32'(signal_out), 32'd1);
                chk("hold_end_busy", 32'(busy), 32'd0);
            end
            if (k == 32) begin
                chk("hold_switch_signal_out", 32'(signal_out), 32'd4);
                phase_inc = 5'd3;
            end
            if (k == 33) chk("hold_switch_wave", 32'(wave_out), 32'd0);
        end

        // Wrap (phase 30 -> 1) then freeze; loop already consumed edge F1.
        for (int j = 2; j <= 17; j++) begin
            @(negedge clk);
            if (j == 11) begin
                chk("wrap_wave_30", 32'(wave_out), 32'd240);
                enable = 1'b0;
            end
            if (j >= 12) chk("freeze_wave", 32'(wave_out), 32'd8);
        end

        // Withdrawn request during the hold window.
        wait_idle();
        enable    = 1'b1;
        phase_inc = 5'd5;
        signal_in = 3'd2;
        for (int k = 0; k <= 35; k++) begin
            @(negedge clk);
            if (k == 2)  signal_in = 3'd6;
            if (k == 10) signal_in = 3'd2;
            if (k >= 1) chk("withdraw_signal_out", 32'(signal_out), 32'd2);
            if (k == 30) chk("withdraw_busy_30", 32'(busy), 32'd1);
            if (k >= 31) chk("withdraw_busy_idle", 32'(busy), 32'd0);
        end

        // Mid-operation reset during a triangle.
        wait_idle();
        signal_in = 3'd6;
        phase_inc = 5'd5;
        for (int k = 0; k <= 3; k++) @(negedge clk);
        chk("tri_busy_before_reset", 32'(busy), 32'd1);
        resetn    = 1'b1;
        signal_in = 3'd0;
        @(negedge clk);
        chk("midreset_signal_out", 32'(signal_out), 32'd0);
        chk("midreset_wave_out", 32'(wave_out), 32'd0);
        chk("midreset_busy", 32'(busy), 32'd0);
        resetn = 1'b0;
        @(negedge clk);

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) signal_in = SW'($urandom_range(0, 7));
            enable    = ($urandom_range(0, 9) != 0);
            phase_inc = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            resetn    = ($urandom_range(0, 99) == 0);
            @(negedge clk);
        end
        resetn = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
